// File: rtl/sva_mon_pkg.sv
// rtl/sva_mon_pkg.sv - shared types, limits and parameter checks for the implication monitor
package sva_mon_pkg;

  localparam int MAX_LEN = 16;

  typedef logic [$clog2(MAX_LEN):0] fail_step_t;

  function automatic bit len_ok(input int n);
    return (n >= 1) && (n <= MAX_LEN);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter, holds at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/seq_impl_monitor.sv
// rtl/seq_impl_monitor.sv - run-time monitor for (a0 ##1 .. aN-1) |->/|=> (c0 ##1 .. cM-1)
module seq_impl_monitor
  import sva_mon_pkg::*;
#(
  parameter  int ANT_LEN = 2,
  parameter  int CON_LEN = 2,
  parameter  int OVERLAP = 0,
  parameter  int CNT_W   = 16,
  localparam int FSW     = $clog2(CON_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               ant_en,
  input  logic               con_en,
  input  logic [ANT_LEN-1:0] ant_i,
  input  logic [CON_LEN-1:0] con_i,
  output logic               pass_o,
  output logic               fail_o,
  output logic [FSW-1:0]     fail_step,
  output logic               active_o,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt
);

  localparam bit OVL = (OVERLAP != 0);

  if (!(len_ok(ANT_LEN) && len_ok(CON_LEN))) begin : g_bad_len
    $error("seq_impl_monitor: ANT_LEN and CON_LEN must be within 1..MAX_LEN");
  end

  logic               ant_tick;
  logic               con_tick;
  logic               ant_done;
  logic               armed;
  logic               pass_d;
  logic               fail_d;
  logic [ANT_LEN-1:0] a_stg;
  logic [ANT_LEN-1:0] a_stg_d;
  logic [CON_LEN-1:0] c_stg;
  logic [CON_LEN-1:0] c_stg_d;
  logic [CON_LEN-1:0] ob;
  logic [CON_LEN-1:0] viol;
  fail_step_t         low_step;

  assign ant_tick = enable & ant_en;
  assign con_tick = enable & con_en;

  if (ANT_LEN == 1) begin : g_ant_one
    assign ant_done = ant_tick & ant_i[0];
  end else begin : g_ant_multi
    assign ant_done = ant_tick & a_stg[ANT_LEN-2] & ant_i[ANT_LEN-1];
  end

  always_comb begin
    a_stg_d    = '0;
    a_stg_d[0] = ant_i[0];
    for (int k = 1; k < ANT_LEN; k++) begin
      a_stg_d[k] = a_stg[k-1] & ant_i[k];
    end
  end

  // c_stg[0] is never set: step 0 obligations come only from armed or an overlapped ant_done
  always_comb begin
    ob       = c_stg;
    ob[0]    = armed | (OVL & ant_done & con_tick);
    viol     = con_tick ? (ob & ~con_i) : '0;
    c_stg_d  = '0;
    for (int k = 1; k < CON_LEN; k++) begin
      c_stg_d[k] = ob[k-1] & con_i[k-1];
    end
    pass_d   = con_tick & ob[CON_LEN-1] & con_i[CON_LEN-1];
    fail_d   = |viol;
    low_step = '0;
    for (int k = CON_LEN - 1; k >= 0; k--) begin
      if (viol[k]) low_step = fail_step_t'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_stg <= '0;
    end else if (ant_tick) begin
      a_stg <= a_stg_d;
    end
  end

  // a fresh completion outranks the clear from a coincident consequent tick
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (ant_done && !(OVL && con_tick)) begin
      armed <= 1'b1;
    end else if (con_tick) begin
      armed <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_stg <= '0;
    end else if (con_tick) begin
      c_stg <= c_stg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_o    <= 1'b0;
      fail_o    <= 1'b0;
      fail_step <= '0;
    end else begin
      pass_o <= pass_d;
      fail_o <= fail_d;
      if (fail_d) fail_step <= low_step[FSW-1:0];
    end
  end

  assign active_o = (|a_stg) | armed | (|c_stg);

  // counters step on the same edge that raises the pulse they count
  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pass_d),
    .cnt (pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk (clk),
    .rst (rst),
    .inc (fail_d),
    .cnt (fail_cnt)
  );

endmodule

// File: tb/tb_seq_impl_monitor.sv
// tb/tb_seq_impl_monitor.sv - bench for seq_impl_monitor, |=> and |-> instances side by side
module tb_seq_impl_monitor;

  localparam int CON = 2;

  logic       clk = 1'b0;
  logic       rst, enable, ant_en, con_en;
  logic [1:0] ant_i, con_i;

  logic        pass_a, fail_a, act_a;
  logic [1:0]  step_a;
  logic [15:0] pc_a, fc_a;
  logic        pass_b, fail_b, act_b;
  logic [1:0]  step_b;
  logic [1:0]  pc_b, fc_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_impl_monitor u_a (
    .clk(clk), .rst(rst), .enable(enable), .ant_en(ant_en), .con_en(con_en),
    .ant_i(ant_i), .con_i(con_i), .pass_o(pass_a), .fail_o(fail_a),
    .fail_step(step_a), .active_o(act_a), .pass_cnt(pc_a), .fail_cnt(fc_a)
  );

  seq_impl_monitor #(.OVERLAP(1), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .enable(enable), .ant_en(ant_en), .con_en(con_en),
    .ant_i(ant_i), .con_i(con_i), .pass_o(pass_b), .fail_o(fail_b),
    .fail_step(step_b), .active_o(act_b), .pass_cnt(pc_b), .fail_cnt(fc_b)
  );

  // reference: history of sampled antecedent vectors plus a list of live attempts by step
  logic [1:0] hist_q[2][$];
  int         att_q[2][$];
  bit         pend[2];
  bit         e_pass[2], e_fail[2], e_act[2];
  int         e_step[2], e_pc[2], e_fc[2];

  function automatic bit prefix_ok(input int id, input int len);
    int n;
    n = hist_q[id].size();
    if (n < len) return 1'b0;
    for (int j = 0; j < len; j++) begin
      if (!hist_q[id][n-len+j][j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step(input int id, input bit r, input bit e, input bit ae, input bit ce,
                            input logic [1:0] a, input logic [1:0] c);
    int  maxc;
    bit  ovl, at, ct, done, p, f;
    int  fs;
    int  starts[$];
    int  nq[$];
    maxc = (id == 0) ? 65535 : 3;
    ovl  = (id == 1);
    if (r) begin
      hist_q[id].delete();
      att_q[id].delete();
      pend[id]   = 1'b0;
      e_pass[id] = 1'b0;
      e_fail[id] = 1'b0;
      e_act[id]  = 1'b0;
      e_step[id] = 0;
      e_pc[id]   = 0;
      e_fc[id]   = 0;
      return;
    end
    at   = e & ae;
    ct   = e & ce;
    done = 1'b0;
    p    = 1'b0;
    f    = 1'b0;
    fs   = CON;
    if (at) begin
      hist_q[id].push_back(a);
      if (hist_q[id].size() > 2) void'(hist_q[id].pop_front());
      done = prefix_ok(id, 2);
    end
    if (ct) begin
      starts = att_q[id];
      if (pend[id] || (ovl && done)) starts.push_front(0);
      foreach (starts[i]) begin
        if (!c[starts[i]]) begin
          f = 1'b1;
          if (starts[i] < fs) fs = starts[i];
        end else if (starts[i] == CON - 1) begin
          p = 1'b1;
        end else begin
          nq.push_back(starts[i] + 1);
        end
      end
      att_q[id] = nq;
    end
    if (done && !(ovl && ct)) pend[id] = 1'b1;
    else if (ct)              pend[id] = 1'b0;
    e_pass[id] = p;
    e_fail[id] = f;
    if (f) e_step[id] = fs;
    if (p && e_pc[id] < maxc) e_pc[id]++;
    if (f && e_fc[id] < maxc) e_fc[id]++;
    e_act[id] = prefix_ok(id, 1) || prefix_ok(id, 2) || pend[id] || (att_q[id].size() > 0);
  endtask

  task automatic check(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0d want=%0d at %0t", name, id, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("pass_o",    0, 32'(pass_a), 32'(e_pass[0]));
    check("fail_o",    0, 32'(fail_a), 32'(e_fail[0]));
    check("fail_step", 0, 32'(step_a), e_step[0]);
    check("active_o",  0, 32'(act_a),  32'(e_act[0]));
    check("pass_cnt",  0, 32'(pc_a),   e_pc[0]);
    check("fail_cnt",  0, 32'(fc_a),   e_fc[0]);
    check("pass_o",    1, 32'(pass_b), 32'(e_pass[1]));
    check("fail_o",    1, 32'(fail_b), 32'(e_fail[1]));
    check("fail_step", 1, 32'(step_b), e_step[1]);
    check("active_o",  1, 32'(act_b),  32'(e_act[1]));
    check("pass_cnt",  1, 32'(pc_b),   e_pc[1]);
    check("fail_cnt",  1, 32'(fc_b),   e_fc[1]);
  endtask

  task automatic cycle(input bit r, input bit e, input bit ae, input bit ce,
                       input logic [1:0] a, input logic [1:0] c);
    rst    = r;
    enable = e;
    ant_en = ae;
    con_en = ce;
    ant_i  = a;
    con_i  = c;
    model_step(0, r, e, ae, ce, a, c);
    model_step(1, r, e, ae, ce, a, c);
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    bit         r;
    logic [1:0] a;
    logic [1:0] c;
    bit         p;
    bit         f;
    logic [1:0] s;
    bit         act;
    int         pc;
    int         fc;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // expected outputs of the |=> instance after each row's clock edge
    tbl[0]  = '{1'b1, 2'b11, 2'b11, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0};
    tbl[1]  = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 2'd0, 1'b1, 0, 0};
    tbl[2]  = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 2'd0, 1'b1, 0, 0};
    tbl[3]  = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 2'd0, 1'b1, 0, 0};
    tbl[4]  = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 2'd0, 1'b1, 1, 0};
    tbl[5]  = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 2'd0, 1'b1, 2, 0};
    tbl[6]  = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 2'd0, 1'b1, 3, 0};
    tbl[7]  = '{1'b1, 2'b11, 2'b11, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0};
    tbl[8]  = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 2'd0, 1'b1, 0, 0};
    tbl[9]  = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 2'd0, 1'b1, 0, 0};
    tbl[10] = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 2'd0, 1'b1, 0, 0};
    tbl[11] = '{1'b0, 2'b11, 2'b01, 1'b0, 1'b1, 2'd1, 1'b1, 0, 1};
    tbl[12] = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 2'd1, 1'b1, 1, 1};
    tbl[13] = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 2'd0, 1'b1, 1, 2};
    tbl[14] = '{1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 2'd0, 1'b1, 1, 2};
    tbl[15] = '{1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 2'd0, 1'b0, 2, 2};
    tbl[16] = '{1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 2'd0, 1'b0, 2, 2};

    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].r, 1'b1, 1'b1, 1'b1, tbl[i].a, tbl[i].c);
      check($sformatf("tbl%0d_pass", i), 0, 32'(pass_a), 32'(tbl[i].p));
      check($sformatf("tbl%0d_fail", i), 0, 32'(fail_a), 32'(tbl[i].f));
      check($sformatf("tbl%0d_step", i), 0, 32'(step_a), 32'(tbl[i].s));
      check($sformatf("tbl%0d_act", i),  0, 32'(act_a),  32'(tbl[i].act));
      check($sformatf("tbl%0d_pcnt", i), 0, 32'(pc_a),   tbl[i].pc);
      check($sformatf("tbl%0d_fcnt", i), 0, 32'(fc_a),   tbl[i].fc);
    end

    // overlapped: consequent step 0 shares the cycle with ant_done
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 2'b00);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 2'b01);
    check("ovl_t1_pass", 1, 32'(pass_b), 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b10);
    check("ovl_t2_pass", 1, 32'(pass_b), 32'd1);
    check("novl_t2_fail", 0, 32'(fail_a), 32'd1);
    check("novl_t2_step", 0, 32'(step_a), 32'd0);

    // sparse consequent ticks leave the handoff armed in between
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00);
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b1, 1'b1, (i % 3) == 2, 2'b11, 2'b11);
      check($sformatf("sparse%0d_act", i),  0, 32'(act_a),  32'd1);
      check($sformatf("sparse%0d_pass", i), 0, 32'(pass_a), 32'(i == 5 || i == 8));
    end

    // saturation of the 2-bit counter
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 2'b11);
    check("sat_pcnt", 1, 32'(pc_b), 32'd3);
    check("unsat_pcnt", 0, 32'(pc_a), 32'd7);

    // reset with consequents in flight and failing inputs present
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 2'b00);
    check("rst_fail", 0, 32'(fail_a), 32'd0);
    check("rst_act",  0, 32'(act_a),  32'd0);
    check("rst_pcnt", 1, 32'(pc_b),   32'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00);
    check("post_rst_fail", 0, 32'(fail_a), 32'd0);

    // freeze mid-attempt, then resume
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 2'b11);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
      check($sformatf("frz%0d_pass", i), 0, 32'(pass_a), 32'd0);
      check($sformatf("frz%0d_fail", i), 0, 32'(fail_a), 32'd0);
      check($sformatf("frz%0d_act", i),  0, 32'(act_a),  32'd1);
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b11);
    check("resume_pass", 0, 32'(pass_a), 32'd1);

    // random traffic against the reference
    for (int i = 0; i < 2000; i++) begin
      logic [1:0] ra, rc;
      ra[0] = ($urandom_range(3) != 0);
      ra[1] = ($urandom_range(3) != 0);
      rc[0] = ($urandom_range(7) != 0);
      rc[1] = ($urandom_range(7) != 0);
      cycle($urandom_range(63) == 0, $urandom_range(7) != 0,
            $urandom_range(3) != 0, $urandom_range(3) != 0, ra, rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
